// File: rtl/phyreset_pkg.sv
// phyreset_pkg: state encodings, default timing constants and
// helpers shared by the multi-channel transceiver reset sequencer.
package phyreset_pkg;

  typedef enum logic [2:0] {
    PLL_PD,
    WAIT_LOCK,
    TX_ANA,
    TX_DIG,
    TX_READY
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_ANA,
    RX_WAIT_LTD,
    RX_DIG,
    RX_READY
  } rx_state_t;

  localparam int NUM_CH_DEF          = 4;
  localparam int PLL_PD_CYC_DEF      = 1000;
  localparam int LOCK_STABLE_CYC_DEF = 64;
  localparam int TX_DIG_DLY_DEF      = 32;
  localparam int LTD_STABLE_CYC_DEF  = 512;
  localparam int RX_TIMEOUT_CYC_DEF  = 100000;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/phyreset_rx_ch.sv
// phyreset_rx_ch: per-channel RX reset sequencer.
// PHYRESET_RX_AUTO_RESTART_EN adds a relock timeout to RX_ANA.
module phyreset_rx_ch
  import phyreset_pkg::*;
#(
  parameter int LTD_STABLE_CYC = LTD_STABLE_CYC_DEF
`ifdef PHYRESET_RX_AUTO_RESTART_EN
  ,
  parameter int RX_TIMEOUT_CYC = RX_TIMEOUT_CYC_DEF
`endif
) (
  input  logic clock,
  input  logic reset_n,
  input  logic cal_busy,
  input  logic locked,
  output logic analogreset,
  output logic digitalreset,
  output logic ready
);

  localparam int LW = $clog2(LTD_STABLE_CYC + 1);

  rx_state_t     state;
  rx_state_t     nxt;
  logic [LW-1:0] cnt;
  logic [LW-1:0] cnt_n;
  logic          tmo_hit;

`ifdef PHYRESET_RX_AUTO_RESTART_EN
  localparam int TW = $clog2(RX_TIMEOUT_CYC + 1);

  logic [TW-1:0] tmo;
  logic [TW-1:0] tmo_n;
  logic          armed;
  logic          armed_n;

  assign tmo_hit = armed && (state == RX_WAIT_LTD)
                && (tmo == TW'(RX_TIMEOUT_CYC - 1));

  // only a lock loss after release arms the timeout
  always_comb begin
    armed_n = 1'b0;
    tmo_n   = '0;
    if (nxt == RX_WAIT_LTD) begin
      if (state == RX_WAIT_LTD) begin
        armed_n = armed;
        tmo_n   = (tmo == '1) ? tmo : tmo + 1'b1;
      end else begin
        armed_n = (state == RX_DIG) || (state == RX_READY);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tmo   <= '0;
      armed <= 1'b0;
    end else begin
      tmo   <= tmo_n;
      armed <= armed_n;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    nxt   = state;
    cnt_n = cnt;
    unique case (state)
      RX_ANA: begin
        if (!cal_busy) begin
          nxt   = RX_WAIT_LTD;
          cnt_n = '0;
        end
      end
      RX_WAIT_LTD: begin
        if (tmo_hit) begin
          nxt   = RX_ANA;
          cnt_n = '0;
        end else if (!locked) begin
          cnt_n = '0;
        end else if (cnt == LW'(LTD_STABLE_CYC - 1)) begin
          nxt   = RX_DIG;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RX_DIG: begin
        nxt = locked ? RX_READY : RX_WAIT_LTD;
      end
      RX_READY: begin
        if (!locked) nxt = RX_WAIT_LTD;
      end
      default: nxt = RX_ANA;
    endcase
    // calibration restarts the channel ahead of any lock event
    if (cal_busy) begin
      nxt   = RX_ANA;
      cnt_n = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= RX_ANA;
      cnt          <= '0;
      analogreset  <= 1'b1;
      digitalreset <= 1'b1;
      ready        <= 1'b0;
    end else begin
      state        <= nxt;
      cnt          <= cnt_n;
      analogreset  <= (nxt == RX_ANA);
      digitalreset <= (nxt == RX_ANA) || (nxt == RX_WAIT_LTD);
      ready        <= (nxt == RX_READY);
    end
  end

endmodule

// File: rtl/phyreset_nch.sv
// phyreset_nch: shared TX/PLL reset sequencer plus per-channel RX.
// Define PHYRESET_RX_AUTO_RESTART_EN for the RX relock timeout.
module phyreset_nch
  import phyreset_pkg::*;
#(
  parameter int NUM_CH          = NUM_CH_DEF,
  parameter int PLL_PD_CYC      = PLL_PD_CYC_DEF,
  parameter int LOCK_STABLE_CYC = LOCK_STABLE_CYC_DEF,
  parameter int TX_DIG_DLY      = TX_DIG_DLY_DEF,
  parameter int LTD_STABLE_CYC  = LTD_STABLE_CYC_DEF,
  parameter int RX_TIMEOUT_CYC  = RX_TIMEOUT_CYC_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              pll_powerdown,
  input  logic              pll_locked,
  input  logic              pll_cal_busy,
  input  logic [NUM_CH-1:0] tx_cal_busy,
  output logic [NUM_CH-1:0] tx_analogreset,
  output logic [NUM_CH-1:0] tx_digitalreset,
  output logic [NUM_CH-1:0] tx_ready,
  input  logic [NUM_CH-1:0] rx_cal_busy,
  input  logic [NUM_CH-1:0] rx_is_lockedtodata,
  output logic [NUM_CH-1:0] rx_analogreset,
  output logic [NUM_CH-1:0] rx_digitalreset,
  output logic [NUM_CH-1:0] rx_ready
);

  localparam int TX_MAX =
    max3(PLL_PD_CYC, LOCK_STABLE_CYC, TX_DIG_DLY);
  localparam int CW = $clog2(TX_MAX + 1);

  if (NUM_CH < 1 || NUM_CH > 16 || PLL_PD_CYC < 1
      || LOCK_STABLE_CYC < 1 || TX_DIG_DLY < 1
      || LTD_STABLE_CYC < 1 || RX_TIMEOUT_CYC < 1)
  begin : g_bad_param
    $error("phyreset_nch: parameter out of range");
  end

  tx_state_t     state;
  tx_state_t     nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          ana_done;
  logic          ana_done_n;
  logic          lock_ok;
  logic          tx_live;

  assign lock_ok = pll_locked && !pll_cal_busy;
  assign tx_live = (state == TX_ANA) || (state == TX_DIG)
                || (state == TX_READY);

  always_comb begin
    nxt        = state;
    cnt_n      = cnt;
    ana_done_n = ana_done;
    unique case (state)
      PLL_PD: begin
        if (cnt == CW'(PLL_PD_CYC - 1)) begin
          nxt   = WAIT_LOCK;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (!lock_ok) begin
          cnt_n = '0;
        end else if (cnt == CW'(LOCK_STABLE_CYC)) begin
          nxt   = TX_ANA;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      TX_ANA: begin
        if (!ana_done) begin
          if (!(|tx_cal_busy)) ana_done_n = 1'b1;
        end else if (cnt == CW'(TX_DIG_DLY - 1)) begin
          nxt   = TX_DIG;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      TX_DIG:   nxt = TX_READY;
      TX_READY: nxt = TX_READY;
      default:  nxt = PLL_PD;
    endcase
    if (tx_live && !pll_locked) begin
      nxt   = WAIT_LOCK;
      cnt_n = '0;
    end
    if (nxt != TX_ANA) ana_done_n = 1'b0;
  end

  // outputs follow the next state so they line up with it
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state           <= PLL_PD;
      cnt             <= '0;
      ana_done        <= 1'b0;
      pll_powerdown   <= 1'b1;
      tx_analogreset  <= '1;
      tx_digitalreset <= '1;
      tx_ready        <= '0;
    end else begin
      state           <= nxt;
      cnt             <= cnt_n;
      ana_done        <= ana_done_n;
      pll_powerdown   <= (nxt == PLL_PD);
      tx_analogreset  <= {NUM_CH{(nxt == PLL_PD)
                         || (nxt == WAIT_LOCK)
                         || ((nxt == TX_ANA) && !ana_done_n)}};
      tx_digitalreset <= {NUM_CH{(nxt != TX_DIG)
                         && (nxt != TX_READY)}};
      tx_ready        <= {NUM_CH{nxt == TX_READY}};
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_rx
    phyreset_rx_ch #(
      .LTD_STABLE_CYC(LTD_STABLE_CYC)
`ifdef PHYRESET_RX_AUTO_RESTART_EN
      ,
      .RX_TIMEOUT_CYC(RX_TIMEOUT_CYC)
`endif
    ) u_rx (
      .clock       (clock),
      .reset_n     (reset_n),
      .cal_busy    (rx_cal_busy[i]),
      .locked      (rx_is_lockedtodata[i]),
      .analogreset (rx_analogreset[i]),
      .digitalreset(rx_digitalreset[i]),
      .ready       (rx_ready[i])
    );
  end

endmodule

// File: tb/tb_phyreset_nch.sv
// tb_phyreset_nch: directed checks of the TX/RX reset sequencing
// with short timing parameters and hand-computed cycle positions.
module tb_phyreset_nch;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       pll_powerdown;
  logic       pll_locked;
  logic       pll_cal_busy;
  logic [3:0] tx_cal_busy;
  logic [3:0] tx_analogreset;
  logic [3:0] tx_digitalreset;
  logic [3:0] tx_ready;
  logic [3:0] rx_cal_busy;
  logic [3:0] rx_is_lockedtodata;
  logic [3:0] rx_analogreset;
  logic [3:0] rx_digitalreset;
  logic [3:0] rx_ready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  phyreset_nch #(
    .NUM_CH         (4),
    .PLL_PD_CYC     (8),
    .LOCK_STABLE_CYC(4),
    .TX_DIG_DLY     (3),
    .LTD_STABLE_CYC (5),
    .RX_TIMEOUT_CYC (20)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .pll_powerdown     (pll_powerdown),
    .pll_locked        (pll_locked),
    .pll_cal_busy      (pll_cal_busy),
    .tx_cal_busy       (tx_cal_busy),
    .tx_analogreset    (tx_analogreset),
    .tx_digitalreset   (tx_digitalreset),
    .tx_ready          (tx_ready),
    .rx_cal_busy       (rx_cal_busy),
    .rx_is_lockedtodata(rx_is_lockedtodata),
    .rx_analogreset    (rx_analogreset),
    .rx_digitalreset   (rx_digitalreset),
    .rx_ready          (rx_ready)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_reset(input string tag);
    chk({tag, ".pd"},   32'(pll_powerdown),   32'h1);
    chk({tag, ".txa"},  32'(tx_analogreset),  32'hF);
    chk({tag, ".txd"},  32'(tx_digitalreset), 32'hF);
    chk({tag, ".txr"},  32'(tx_ready),        32'h0);
    chk({tag, ".rxa"},  32'(rx_analogreset),  32'hF);
    chk({tag, ".rxd"},  32'(rx_digitalreset), 32'hF);
    chk({tag, ".rxr"},  32'(rx_ready),        32'h0);
  endtask

  // k counts clocks from reset release; drop_at marks a lock-low clock
  task automatic tx_seq(
    input string tag,
    input int    ready_at,
    input int    drop_at
  );
    for (int k = 1; k <= ready_at; k++) begin
      pll_locked = (k != drop_at);
      tick();
      chk($sformatf("%s.pd@%0d", tag, k),
          32'(pll_powerdown), 32'(k < 8));
      chk($sformatf("%s.txa@%0d", tag, k),
          32'(tx_analogreset), (k < ready_at - 4) ? 32'hF : 32'h0);
      chk($sformatf("%s.txd@%0d", tag, k),
          32'(tx_digitalreset), (k < ready_at - 1) ? 32'hF : 32'h0);
      chk($sformatf("%s.txr@%0d", tag, k),
          32'(tx_ready), (k >= ready_at) ? 32'hF : 32'h0);
    end
    pll_locked = 1'b1;
    chk({tag, ".rxr"}, 32'(rx_ready), 32'hF);
  endtask

  initial begin
    reset_n            = 1'b0;
    pll_locked         = 1'b1;
    pll_cal_busy       = 1'b0;
    tx_cal_busy        = 4'h0;
    rx_cal_busy        = 4'h0;
    rx_is_lockedtodata = 4'hF;

    repeat (3) tick();
    chk_all_reset("rst");

    reset_n = 1'b1;
    tx_seq("boot", 18, 0);

    // one-clock reset pulse while fully ready
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk_all_reset("pulse");
    tx_seq("rerun", 18, 0);

    // PLL lock loss from TX_READY, then relock
    pll_locked = 1'b0;
    tick();
    chk("ploss.txr", 32'(tx_ready), 32'h0);
    chk("ploss.txa", 32'(tx_analogreset), 32'hF);
    chk("ploss.txd", 32'(tx_digitalreset), 32'hF);
    chk("ploss.pd", 32'(pll_powerdown), 32'h0);
    pll_locked = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      tick();
      chk($sformatf("relock.txa@%0d", j),
          32'(tx_analogreset), (j < 6) ? 32'hF : 32'h0);
      chk($sformatf("relock.txr@%0d", j),
          32'(tx_ready), (j == 10) ? 32'hF : 32'h0);
    end

    // channel 2 loses data lock for one clock
    rx_is_lockedtodata = 4'hB;
    tick();
    chk("ltd2.rxr", 32'(rx_ready), 32'hB);
    chk("ltd2.rxd", 32'(rx_digitalreset), 32'h4);
    chk("ltd2.rxa", 32'(rx_analogreset), 32'h0);
    rx_is_lockedtodata = 4'hF;
    repeat (5) tick();
    chk("ltd2.rxd5", 32'(rx_digitalreset), 32'h0);
    chk("ltd2.rxr5", 32'(rx_ready), 32'hB);
    tick();
    chk("ltd2.rxr6", 32'(rx_ready), 32'hF);
    chk("ltd2.txr", 32'(tx_ready), 32'hF);

    // channel 1 lock lost with no return
    rx_is_lockedtodata = 4'hD;
    tick();
    chk("tmo.rxr", 32'(rx_ready), 32'hD);
    repeat (19) tick();
    chk("tmo.rxa19", 32'(rx_analogreset), 32'h0);
    tick();
`ifdef PHYRESET_RX_AUTO_RESTART_EN
    chk("tmo.rxa20", 32'(rx_analogreset), 32'h2);
`else
    chk("tmo.rxa20", 32'(rx_analogreset), 32'h0);
`endif
    rx_is_lockedtodata = 4'hF;
    repeat (10) tick();
    chk("tmo.rxr", 32'(rx_ready), 32'hF);

    // calibration and lock loss together on channel 0
    rx_cal_busy        = 4'h1;
    rx_is_lockedtodata = 4'hE;
    tick();
    chk("cal0.rxa", 32'(rx_analogreset), 32'h1);
    chk("cal0.rxd", 32'(rx_digitalreset), 32'h1);
    chk("cal0.rxr", 32'(rx_ready), 32'hE);
    rx_cal_busy        = 4'h0;
    rx_is_lockedtodata = 4'hF;
    tick();
    chk("cal0.rxa1", 32'(rx_analogreset), 32'h0);
    chk("cal0.rxd1", 32'(rx_digitalreset), 32'h1);

    // lock glitch on the third WAIT_LOCK clock
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tx_seq("glitch", 21, 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/phyreset_nch.md
PHYRESET_NCH -- requirements
Module: phyreset_nch

Interface
REQ-001 SHALL provide parameter NUM_CH, default 4, number of transceiver channels (1..16).
REQ-002 SHALL provide parameter PLL_PD_CYC, default 1000, pll_powerdown pulse length in clocks (>=1).
REQ-003 SHALL provide parameter LOCK_STABLE_CYC, default 64, clocks of continuous pll_locked before TX release (>=1).
REQ-004 SHALL provide parameter TX_DIG_DLY, default 32, clocks from tx_analogreset deassert to tx_digitalreset deassert (>=1).
REQ-005 SHALL provide parameter LTD_STABLE_CYC, default 512, clocks of continuous rx_is_lockedtodata before RX digital release (>=1).
REQ-006 SHALL provide parameter RX_TIMEOUT_CYC, default 100000, relock timeout used only under the Configuration macro.
REQ-007 SHALL provide ports: clock in 1 system clock; reset_n in 1 synchronous active-low reset.
REQ-008 SHALL provide ports: pll_powerdown out 1; pll_locked in 1; pll_cal_busy in 1.
REQ-009 SHALL provide ports: tx_cal_busy in NUM_CH; tx_analogreset, tx_digitalreset, tx_ready out NUM_CH.
REQ-010 SHALL provide ports: rx_cal_busy, rx_is_lockedtodata in NUM_CH; rx_analogreset, rx_digitalreset, rx_ready out NUM_CH.
REQ-011 SHALL treat all inputs as synchronous to clock; external synchronisers are the integrator's responsibility.

Function
REQ-012 SHALL register every output; no combinational input-to-output path.
REQ-013 SHALL run one shared TX FSM: PLL_PD -> WAIT_LOCK -> TX_ANA -> TX_DIG -> TX_READY.
REQ-014 PLL_PD: pll_powerdown=1, all TX resets=1, tx_ready=0; exit after exactly PLL_PD_CYC clocks.
REQ-015 WAIT_LOCK: pll_powerdown=0; advance once pll_locked=1 and pll_cal_busy=0 hold for LOCK_STABLE_CYC consecutive clocks; any drop restarts the count.
REQ-016 TX_ANA: deassert all tx_analogreset once all tx_cal_busy=0; then wait TX_DIG_DLY clocks.
REQ-017 TX_DIG: deassert all tx_digitalreset; assert all tx_ready one clock later (TX_READY).
REQ-018 pll_locked=0 in TX_ANA/TX_DIG/TX_READY SHALL reassert all TX resets, clear tx_ready next clock, return to WAIT_LOCK.
REQ-019 SHALL run NUM_CH independent RX FSMs: RX_ANA -> RX_WAIT_LTD -> RX_DIG -> RX_READY, independent of TX state.
REQ-020 RX_ANA: both RX resets=1; advance when rx_cal_busy=0 for that channel.
REQ-021 RX_WAIT_LTD: rx_analogreset=0, rx_digitalreset=1; advance after LTD_STABLE_CYC consecutive rx_is_lockedtodata=1.
REQ-022 RX_DIG: rx_digitalreset=0; rx_ready=1 one clock later (RX_READY).
REQ-023 rx_is_lockedtodata=0 in RX_DIG/RX_READY SHALL reassert that channel's rx_digitalreset, clear rx_ready, go to RX_WAIT_LTD; other channels unaffected.
REQ-024 rx_cal_busy=1 in any RX state other than RX_ANA SHALL force that channel to RX_ANA; takes priority over REQ-023 when simultaneous.
REQ-025 Counters SHALL be $clog2(max+1) bits and saturate; no wrap-around.

Reset
REQ-026 reset_n=0 sampled at a clock edge SHALL force TX FSM to PLL_PD, all RX FSMs to RX_ANA, clear counters, and drive pll_powerdown=1, all analog/digital resets=1, all ready=0 from the next clock, including mid-sequence.
REQ-027 After reset_n rises, the PLL_PD count SHALL start on the first clock with reset_n=1.

Configuration
REQ-028 With PHYRESET_RX_AUTO_RESTART_EN defined, a channel remaining in RX_WAIT_LTD for RX_TIMEOUT_CYC clocks after entry from RX_DIG/RX_READY SHALL return to RX_ANA (full analog restart).
REQ-029 Without PHYRESET_RX_AUTO_RESTART_EN, RX_WAIT_LTD SHALL wait indefinitely and the timeout counter SHALL not be instantiated.

Structure
REQ-030 Package phyreset_pkg SHALL hold the TX and RX state enums and default parameter constants.
REQ-031 Per-channel RX FSM SHALL be sub-module phyreset_rx_ch, generated NUM_CH times.

Verification (NUM_CH=4, PLL_PD_CYC=8, LOCK_STABLE_CYC=4, TX_DIG_DLY=3, LTD_STABLE_CYC=5, RX_TIMEOUT_CYC=20)
REQ-032 Reset release, pll_locked=1, cal_busy=0 -> pll_powerdown high 8 clocks, tx_ready=4'hF exactly 8+4+1+3+1+1 clocks after release, ±0 cycles.
REQ-033 pll_locked pulses low 1 clock at count 3 of WAIT_LOCK -> stable count restarts, tx_ready delayed by 3 clocks.
REQ-034 Channel 2 rx_is_lockedtodata drops in RX_READY -> rx_ready=4'hB next clock, rx_digitalreset[2]=1; relock for 5 clocks -> rx_ready=4'hF.
REQ-035 Macro defined, channel 1 lock lost and never returns -> rx_analogreset[1]=1 after 20 clocks; macro undefined -> rx_analogreset[1] stays 0.
REQ-036 reset_n low for 1 clock while in TX_READY -> all ready=0, all resets=1, pll_powerdown=1 next clock; full sequence repeats.
REQ-037 rx_cal_busy[0]=1 and rx_is_lockedtodata[0]=0 in same clock -> channel 0 enters RX_ANA (rx_analogreset[0]=1).
